// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states: idle, serving the fetch port, serving the data port.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam int DEF_LATENCY    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Memory is word addressed; byte offset bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_valid, i_rdata, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Environment side: requesters plus memory.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_valid, i_rdata, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch (I)
// and load/store (D) requesters. D has priority; I wins after STARVE_MAX
// consecutive lost arbitrations.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SC_W-1:0]  sc_q,    sc_d;
    logic [31:0]      addr_q,  addr_d;
    logic             we_q,    we_d;
    logic [31:0]      wdata_q, wdata_d;

    logic grant_i_s;
    logic grant_d_s;
    logic busy_s;
    logic last_s;

    // IDLE-cycle arbitration: D first unless I has been starved long enough.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (bus.d_req && bus.i_req) begin
                if (sc_q == SC_MAX) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_d_s = 1'b1;
                end
            end else if (bus.i_req) begin
                grant_i_s = 1'b1;
            end else if (bus.d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
        end
    end

    // Next-state logic: latch the winning request, then count down the access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_i_s) begin
                    state_d = ARB_BUSY_I;
                    cnt_d   = CNT_LOAD;
                    sc_d    = '0;
                    addr_d  = word_align(bus.i_addr);
                    we_d    = 1'b0;
                    wdata_d = 32'h0000_0000;
                end else if (grant_d_s) begin
                    state_d = ARB_BUSY_D;
                    cnt_d   = CNT_LOAD;
                    // Only a D win over a waiting I counts toward starvation.
                    sc_d    = bus.i_req ? (sc_q + SC_W'(1)) : '0;
                    addr_d  = word_align(bus.d_addr);
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and latch registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            sc_q    <= '0;
            addr_q  <= 32'h0000_0000;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_s = (state_q != ARB_IDLE);
    assign last_s = busy_s && (cnt_q == '0);

    // Completion strobes are suppressed while reset is asserted so that an
    // aborted access neither writes memory nor signals completion.
    assign bus.mem_en    = busy_s;
    assign bus.mem_addr  = busy_s ? addr_q  : 32'h0000_0000;
    assign bus.mem_wdata = busy_s ? wdata_q : 32'h0000_0000;
    assign bus.mem_we    = last_s && (state_q == ARB_BUSY_D) && we_q && reset;
    assign bus.i_valid   = last_s && (state_q == ARB_BUSY_I) && reset;
    assign bus.d_valid   = last_s && (state_q == ARB_BUSY_D) && reset;

    // Read data flows straight from memory during the valid cycle only.
    assign bus.i_rdata = bus.i_valid ? bus.mem_rdata : 32'h0000_0000;
    assign bus.d_rdata = (bus.d_valid && !we_q) ? bus.mem_rdata : 32'h0000_0000;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency word memory between the pipeline's instruction-fetch requester (I, read-only) and its MEM-stage requester (D, load/store). Sequences each access over `LATENCY` cycles, returns data with a one-cycle valid pulse, and gives D priority with a starvation guard for I. The IF and MEM stages stall on their own `*_req & ~*_valid`.

## Interface
- `LATENCY`, 2: memory access cycles, ≥1.
- `STARVE_MAX`, 4: consecutive lost arbitrations after which I wins, ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_valid`.
- `i_addr`  in  32  fetch byte address.
- `i_valid`  out  1  one-cycle pulse; `i_rdata` valid.
- `i_rdata`  out  32  fetched word.
- `d_req`  in  1  data request; held until `d_valid`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_valid`  out  1  one-cycle pulse; load data valid or store committed.
- `d_rdata`  out  32  load word; 0 for stores.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  write strobe; memory commits on the edge ending the cycle.
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  memory read data, valid in the final access cycle.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Down-counter `cnt` is `$clog2(LATENCY+1)` bits. Starve counter `sc` counts to STARVE_MAX.
- IDLE arbitration, evaluated each cycle:
  - If `d_req & i_req`: grant I when `sc==STARVE_MAX`, otherwise grant D and increment `sc`.
  - If only one request is present, grant it.
  - Granting I clears `sc`. Granting D when `i_req` is low also clears `sc`.
- On a grant, latch the address, `d_we` and `d_wdata`, load `cnt=LATENCY-1`, and move to BUSY_I or BUSY_D.
- BUSY:
  - `mem_en=1`, `mem_addr` and `mem_wdata` come from the latched values.
  - `cnt` decrements each cycle.
  - When `cnt==0`: pulse the owner's valid, and for BUSY_D with a store assert `mem_we`. The next state is IDLE.
- `mem_we` is asserted only in the final BUSY_D cycle. An aborted store therefore never writes.
- Read data is passed through combinationally: `i_rdata`/`d_rdata = mem_rdata` during the valid cycle, 0 otherwise.
- Request inputs are ignored outside IDLE. Changes to address or data after the grant have no effect.
- `d_addr[1:0]` and `i_addr[1:0]` are ignored (word access only).

## Timing
- Reset (`reset==0` at an edge): state=IDLE, `cnt=0`, `sc=0`, latches cleared. All outputs are 0 from the next cycle onward.
- Reset mid-transaction aborts it with no valid pulse and no write.
- Latency: a grant in IDLE cycle t gives valid in cycle t+LATENCY.
- A mandatory IDLE cycle follows every completion; peak throughput is one access per LATENCY+1 cycles.
- A requester drops or changes `req` the cycle after its valid. The following IDLE cycle sees only new requests, so there is no double issue.
- Both requests asserted with `sc<STARVE_MAX`: D wins.
- With LATENCY=1, BUSY lasts one cycle. `cnt` starts at 0, so valid occurs in the first BUSY cycle.
- Outputs `i_valid`, `d_valid`, `mem_*` are decoded from registered state only, with no combinational path from `*_req`. Read data is the only combinational output path, from `mem_rdata`.

## Structure
- Package `mem_arb_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY_I`, `ARB_BUSY_D`), default LATENCY/STARVE_MAX constants, `word_align()` function.
- Single module. No sub-module is warranted; the counters and FSM stay inline.

## Test plan
- LATENCY=2. Single I req to 0x10, with the memory returning 0xDEADBEEF → `i_valid` pulses at t+2 with `i_rdata`=0xDEADBEEF, `mem_addr`=0x10, `mem_we` never high.
- D store to 0x23 with data 0x12345678 → `mem_addr`=0x20, `mem_we` high only in cycle t+2, `d_valid` at t+2, `d_rdata`=0.
- `i_req` and `d_req` held continuously, STARVE_MAX=4 → grant order D,D,D,D,I repeating; I valid every 15 cycles.
- Back-to-back D loads with `req` re-asserted the cycle after valid → exactly one IDLE cycle between BUSY_D runs; no duplicate grant.
- Reset low in the last BUSY_D cycle of a store → no `mem_we` at that edge, no `d_valid`; next cycle IDLE with all outputs 0.
- LATENCY=1, alternating single I and D requests → each valid occurs 1 cycle after its grant; `sc` stays 0.
